// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S frame sequencer: format codes, FSM states
// and the per-format block count / mask lookups.
package i2s_pkg;

    localparam logic [7:0] SZ_8  = 8'd0;
    localparam logic [7:0] SZ_12 = 8'd1;
    localparam logic [7:0] SZ_16 = 8'd3;
    localparam logic [7:0] SZ_24 = 8'd4;
    localparam logic [7:0] SZ_32 = 8'd5;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT_L,
        COLLECT_R,
        HOLD
    } state_t;

    function automatic logic fmt_valid(input logic [7:0] code);
        logic ok;
        case (code)
            SZ_8, SZ_12, SZ_16, SZ_24, SZ_32: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unsupported codes fall back to the 16-bit layout.
    function automatic logic [CNT_W-1:0] fmt_blocks(input logic [7:0] code);
        logic [CNT_W-1:0] n;
        case (code)
            SZ_8:    n = CNT_W'(1);
            SZ_12:   n = CNT_W'(2);
            SZ_24:   n = CNT_W'(3);
            SZ_32:   n = CNT_W'(4);
            default: n = CNT_W'(2);
        endcase
        return n;
    endfunction

    function automatic logic [31:0] fmt_mask(input logic [7:0] code);
        logic [31:0] m;
        case (code)
            SZ_8:    m = 32'h0000_00FF;
            SZ_12:   m = 32'h0000_0FFF;
            SZ_24:   m = 32'h00FF_FFFF;
            SZ_32:   m = 32'hFFFF_FFFF;
            default: m = 32'h0000_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/i2s_frame_sequencer_if.sv
// Byte-stream input and frame output handshakes of the frame sequencer.
interface i2s_frame_sequencer_if #(
    parameter int SAMPLE_W = 32
);
    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic [SAMPLE_W-1:0] frame_left;
    logic [SAMPLE_W-1:0] frame_right;
    logic                frame_valid;
    logic                frame_ready;

    modport master (
        output byte_in, byte_valid, frame_ready,
        input  byte_ready, frame_left, frame_right, frame_valid
    );

    modport slave (
        input  byte_in, byte_valid, frame_ready,
        output byte_ready, frame_left, frame_right, frame_valid
    );
endinterface

// File: rtl/sample_assembler.sv
// Little-endian byte shift-in for one sample; raises done on the transfer
// that completes the sample and presents the masked word in the same cycle.
module sample_assembler
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [7:0]          byte_in,
    input  logic [CNT_W-1:0]    blocks,
    input  logic [SAMPLE_W-1:0] mask,
    output logic [SAMPLE_W-1:0] word,
    output logic                done
);
    localparam int LANES = SAMPLE_W / 8;

    logic [SAMPLE_W-1:0] asm_reg;
    logic [SAMPLE_W-1:0] asm_next;
    logic [CNT_W-1:0]    byte_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign asm_next[gi*8 +: 8] = (en && byte_cnt_reg == CNT_W'(gi))
                                       ? byte_in : asm_reg[gi*8 +: 8];
        end
    endgenerate

    assign done = en && (byte_cnt_reg == blocks - CNT_W'(1));
    assign word = asm_next & mask;

    // A completed sample leaves the register so the next one starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clear || done) begin
            asm_reg      <= '0;
            byte_cnt_reg <= '0;
        end else if (en) begin
            asm_reg      <= asm_next;
            byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/i2s_frame_sequencer.sv
// Collects USB audio bytes into left/right frames for the I2S serialiser,
// with format latched at frame-sequence start and a hold stage for backpressure.
module i2s_frame_sequencer
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = 32,
    parameter int CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] sample_size,
    input  logic              stereo,
    input  logic              flush,
    output logic              cfg_err,
    i2s_frame_sequencer_if.slave bus
);
    state_t              state_reg;
    logic                byte_ready_reg;
    logic                frame_valid_reg;
    logic [SAMPLE_W-1:0] left_reg;
    logic [SAMPLE_W-1:0] right_reg;
    logic                cfg_err_reg;
    logic [CNT_W-1:0]    blocks_reg;
    logic [SAMPLE_W-1:0] mask_reg;
    logic                stereo_reg;

    logic [7:0]          code_ext;
    logic                xfer;
    logic                asm_clear;
    logic [SAMPLE_W-1:0] word;
    logic                done;

    assign code_ext  = 8'(sample_size);
    assign xfer      = bus.byte_valid && byte_ready_reg && !flush;
    assign asm_clear = flush || (state_reg == IDLE);

    sample_assembler #(.SAMPLE_W(SAMPLE_W)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .en      (xfer),
        .byte_in (bus.byte_in),
        .blocks  (blocks_reg),
        .mask    (mask_reg),
        .word    (word),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            byte_ready_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            left_reg        <= '0;
            right_reg       <= '0;
            cfg_err_reg     <= 1'b0;
            blocks_reg      <= '0;
            mask_reg        <= '0;
            stereo_reg      <= 1'b0;
        end else if (flush) begin
            state_reg       <= IDLE;
            byte_ready_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg      <= COLLECT_L;
                    byte_ready_reg <= 1'b1;
                    blocks_reg     <= fmt_blocks(code_ext);
                    mask_reg       <= SAMPLE_W'(fmt_mask(code_ext));
                    stereo_reg     <= stereo;
                    if (!fmt_valid(code_ext))
                        cfg_err_reg <= 1'b1;
                end
                COLLECT_L: begin
                    if (done) begin
                        left_reg <= word;
                        if (stereo_reg) begin
                            state_reg <= COLLECT_R;
                        end else begin
                            right_reg       <= word;
                            state_reg       <= HOLD;
                            byte_ready_reg  <= 1'b0;
                            frame_valid_reg <= 1'b1;
                        end
                    end
                end
                COLLECT_R: begin
                    if (done) begin
                        right_reg       <= word;
                        state_reg       <= HOLD;
                        byte_ready_reg  <= 1'b0;
                        frame_valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    // Config stays latched across frames; only flush/rst re-read it.
                    if (bus.frame_ready) begin
                        state_reg       <= COLLECT_L;
                        byte_ready_reg  <= 1'b1;
                        frame_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready  = byte_ready_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.frame_left  = left_reg;
    assign bus.frame_right = right_reg;
    assign cfg_err         = cfg_err_reg;
endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench for i2s_frame_sequencer: formats, backpressure, flush,
// config latching, invalid code and mid-frame reset.
module tb_i2s_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sample_size = 4'd3;
    logic       stereo = 1'b1;
    logic       flush = 1'b0;
    logic       cfg_err;

    int tests = 0;
    int fails = 0;

    i2s_frame_sequencer_if #(.SAMPLE_W(32)) bus ();

    i2s_frame_sequencer #(.SAMPLE_W(32), .CODE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_size (sample_size),
        .stereo      (stereo),
        .flush       (flush),
        .cfg_err     (cfg_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.byte_valid = 1'b0;
        repeat (gap) step();
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("byte_ready_timeout", {31'd0, bus.byte_ready}, 32'd1);
        step();
        bus.byte_valid = 1'b0;
        $display("[TB] byte 0x%02h sent (gap %0d)", b, gap);
    endtask

    task automatic consume(input string tag);
        check({tag, "_fv_before"}, {31'd0, bus.frame_valid}, 32'd1);
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        check({tag, "_fv_after"}, {31'd0, bus.frame_valid}, 32'd0);
        check({tag, "_br_after"}, {31'd0, bus.byte_ready}, 32'd1);
        $display("[TB] frame %s consumed", tag);
    endtask

    task automatic restart(input logic [3:0] code, input logic st);
        flush       = 1'b1;
        sample_size = code;
        stereo      = st;
        step();
        flush = 1'b0;
        step();
        $display("[TB] flush/relatch code %0d stereo %0d", code, st);
    endtask

    initial begin
        bus.byte_in     = 8'h00;
        bus.byte_valid  = 1'b0;
        bus.frame_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("rst_left", bus.frame_left, 32'd0);
        check("rst_right", bus.frame_right, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_to_collect", {31'd0, bus.byte_ready}, 32'd1);

        // Stereo 16b, no gaps
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'h78, 0);
        check("s16_fv_early", {31'd0, bus.frame_valid}, 32'd0);
        send_byte(8'h56, 0);
        check("s16_fv", {31'd0, bus.frame_valid}, 32'd1);
        check("s16_left", bus.frame_left, 32'h0000_1234);
        check("s16_right", bus.frame_right, 32'h0000_5678);
        check("s16_br_hold", {31'd0, bus.byte_ready}, 32'd0);
        consume("s16");

        // Mono 24b with 10 cycles of backpressure
        restart(4'd4, 1'b0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        check("m24_left", bus.frame_left, 32'h00CC_BBAA);
        check("m24_right", bus.frame_right, 32'h00CC_BBAA);
        for (int i = 0; i < 10; i++) begin
            step();
            check("m24_hold_br", {31'd0, bus.byte_ready}, 32'd0);
            check("m24_hold_fv", {31'd0, bus.frame_valid}, 32'd1);
            check("m24_hold_left", bus.frame_left, 32'h00CC_BBAA);
        end
        consume("m24");

        // 12b stereo, all-ones bytes get masked
        restart(4'd1, 1'b1);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        check("s12_left", bus.frame_left, 32'h0000_0FFF);
        check("s12_right", bus.frame_right, 32'h0000_0FFF);
        consume("s12");

        // 32b mono
        restart(4'd5, 1'b0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        check("m32_left", bus.frame_left, 32'h0403_0201);
        check("m32_right", bus.frame_right, 32'h0403_0201);
        consume("m32");

        // Partial 32b frame, flush coinciding with a byte, then 8b stereo
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        bus.byte_in    = 8'hEE;
        bus.byte_valid = 1'b1;
        flush          = 1'b1;
        sample_size    = 4'd0;
        stereo         = 1'b1;
        step();
        bus.byte_valid = 1'b0;
        flush          = 1'b0;
        check("flush_br_idle", {31'd0, bus.byte_ready}, 32'd0);
        check("flush_fv", {31'd0, bus.frame_valid}, 32'd0);
        step();
        check("flush_br_collect", {31'd0, bus.byte_ready}, 32'd1);
        send_byte(8'h11, 1);
        check("s8_fv_mid", {31'd0, bus.frame_valid}, 32'd0);
        send_byte(8'h22, 0);
        check("s8_left", bus.frame_left, 32'h0000_0011);
        check("s8_right", bus.frame_right, 32'h0000_0022);
        consume("s8");

        // sample_size change mid-frame is ignored until flush
        restart(4'd3, 1'b0);
        send_byte(8'h01, 0);
        sample_size = 4'd0;
        check("latch_fv_mid", {31'd0, bus.frame_valid}, 32'd0);
        send_byte(8'h02, 0);
        check("latch_left", bus.frame_left, 32'h0000_0201);
        check("latch_right", bus.frame_right, 32'h0000_0201);
        consume("latch1");
        send_byte(8'h03, 0);
        check("latch2_fv_mid", {31'd0, bus.frame_valid}, 32'd0);
        send_byte(8'h04, 0);
        check("latch2_left", bus.frame_left, 32'h0000_0403);
        consume("latch2");
        restart(4'd0, 1'b0);
        send_byte(8'h5A, 0);
        check("relatch_fv", {31'd0, bus.frame_valid}, 32'd1);
        check("relatch_left", bus.frame_left, 32'h0000_005A);
        check("relatch_right", bus.frame_right, 32'h0000_005A);
        consume("relatch");
        check("cfg_err_clean", {31'd0, cfg_err}, 32'd0);

        // Unsupported code 7 behaves as 16b and sets sticky cfg_err
        restart(4'd7, 1'b1);
        check("cfg_err_set", {31'd0, cfg_err}, 32'd1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        check("c7_fv_mid", {31'd0, bus.frame_valid}, 32'd0);
        send_byte(8'h04, 0);
        check("c7_left", bus.frame_left, 32'h0000_0201);
        check("c7_right", bus.frame_right, 32'h0000_0403);
        consume("c7");
        restart(4'd3, 1'b1);
        check("cfg_err_sticky", {31'd0, cfg_err}, 32'd1);

        // Gapped bytes, then reset in the middle of the right sample
        send_byte(8'h10, $urandom_range(0, 3));
        send_byte(8'h20, $urandom_range(0, 3));
        send_byte(8'h30, $urandom_range(0, 3));
        check("gap_fv_mid", {31'd0, bus.frame_valid}, 32'd0);
        rst = 1'b1;
        step();
        check("mrst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("mrst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("mrst_left", bus.frame_left, 32'd0);
        check("mrst_right", bus.frame_right, 32'd0);
        check("mrst_cfg_err", {31'd0, cfg_err}, 32'd0);
        rst = 1'b0;
        step();
        check("mrst_collect", {31'd0, bus.byte_ready}, 32'd1);
        send_byte(8'h0D, $urandom_range(0, 2));
        send_byte(8'h0C, $urandom_range(0, 2));
        send_byte(8'h0B, $urandom_range(0, 2));
        send_byte(8'h0A, $urandom_range(0, 2));
        check("post_rst_left", bus.frame_left, 32'h0000_0C0D);
        check("post_rst_right", bus.frame_right, 32'h0000_0A0B);
        consume("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
- Sequences the byte stream from the USB receive path into complete audio frames (left + right sample) for the I2S transmitter.
- Owns the byte-assembly datapath: byte counting, per-format block count, masking and channel order.
- Exposes a valid/ready handshake on both sides, so neither the USB side nor the I2S side needs edge-triggered strobes.
- Sits between the USB endpoint FIFO and the I2S serialiser.

Parameters:
- SAMPLE_W, 32, width of each output sample word.
- CODE_W, 4, width of the sample_size code.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- byte_in  in  8  audio byte from the USB receive FIFO.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  sequencer accepts byte_in this cycle; a byte transfers when byte_valid && byte_ready.
- sample_size  in  CODE_W  format code: 0=8b, 1=12b, 3=16b, 4=24b, 5=32b.
- stereo  in  1  1 = L then R per frame; 0 = mono, one sample copied to both channels.
- flush  in  1  discard any partial frame and return to IDLE.
- frame_left  out  SAMPLE_W  left sample, zero-extended.
- frame_right  out  SAMPLE_W  right sample, zero-extended.
- frame_valid  out  1  frame registers hold a complete frame.
- frame_ready  in  1  I2S side consumes the frame when frame_valid && frame_ready.
- cfg_err  out  1  sticky: an unsupported sample_size code was latched.

Behaviour:
- Reset values: byte_ready=0, frame_valid=0, frame_left=0, frame_right=0, cfg_err=0, state=IDLE, byte_cnt=0, assembly register=0.
- Config latch:
  - sample_size and stereo are sampled only on the IDLE->COLLECT_L transition.
  - Changes while a frame is in progress are ignored until the next IDLE.
- Block count and mask per code:
  - 0: 1 block, mask 0xFF.
  - 1: 2 blocks, mask 0xFFF.
  - 3: 2 blocks, mask 0xFFFF.
  - 4: 3 blocks, mask 0xFFFFFF.
  - 5: 4 blocks, mask 0xFFFFFFFF.
  - Any other code: treated as code 3; cfg_err set and held until rst.
- Byte order: little-endian. The first accepted byte of a sample goes to bits [7:0], the k-th to bits [8k+7:8k]. Unused upper bytes are 0. The mask is applied when the sample is stored.
- States:
  - IDLE: byte_ready=0. Next cycle go to COLLECT_L, latch config, clear byte_cnt.
  - COLLECT_L: byte_ready=1. Each transfer writes one byte and increments byte_cnt. When a transfer occurs with byte_cnt==blocks-1, store the masked word in the left holding register and clear byte_cnt. Then go to COLLECT_R if stereo, else HOLD with right := left.
  - COLLECT_R: same as COLLECT_L; the last byte stores the right sample and moves to HOLD.
  - HOLD: byte_ready=0, frame_valid=1, frame outputs stable. On frame_valid && frame_ready: frame_valid drops next cycle, state goes to COLLECT_L directly (config stays latched), byte_cnt=0.
  - Config is re-latched only after flush or rst.
- Latency:
  - frame_valid rises the cycle after the last byte of the frame is accepted.
  - byte_ready rises the cycle after the consuming handshake.
  - Sustained throughput is 1 byte per cycle during collection.
- byte_valid low stalls collection without losing state. byte_cnt never exceeds blocks-1, so there is no wrap-around.
- flush:
  - Takes effect next cycle from any state: clears byte_cnt and the partial assembly, frame_valid=0, state=IDLE.
  - A frame held in HOLD is dropped.
  - flush has priority over a simultaneous byte or frame handshake, and that transfer is not counted.
- rst has priority over flush. rst mid-frame discards everything and restores the reset values above.
- Outputs are registered. byte_ready depends only on state, never combinationally on byte_valid or frame_ready.

Decomposition:
- Shared package i2s_pkg:
  - sample_size code constants (SZ_8, SZ_12, SZ_16, SZ_24, SZ_32).
  - the state enum.
  - function fmt_blocks(code) returning the block count.
  - function fmt_mask(code) returning the mask.
  - function fmt_valid(code) flagging supported codes.
- One sub-module, sample_assembler: byte shift-in register, byte_cnt, mask and done pulse. The parent FSM instantiates it and steers the stored word to L or R.

Test Plan:
- Stereo 16b (code 3): bytes 34,12,78,56 streamed with no gaps -> frame_left=0x00001234, frame_right=0x00005678; frame_valid rises the cycle after byte 4.
- Mono 24b (code 4): bytes AA,BB,CC -> left=right=0x00CCBBAA. Hold frame_ready=0 for 10 cycles -> byte_ready stays 0 and outputs stay stable. Pulse frame_ready -> byte_ready=1 the next cycle.
- 12b (code 1): bytes FF,FF per channel -> both samples 0x00000FFF. 32b (code 5): 01,02,03,04 -> 0x04030201.
- Partial frame then flush after 2 of 4 bytes, followed by a full frame of 8b stereo 11,22 -> left=0x11, right=0x22, with no stale bytes.
- Change sample_size from 3 to 0 mid-frame -> the current frame still uses 2 blocks; the new format applies only after flush. Code 7 -> behaves as 16b and cfg_err=1 until rst.
- Random byte_valid gaps, then rst asserted mid-COLLECT_R -> all outputs at reset values next cycle; the following frame assembles correctly.
